// File: rtl/qpsk_tx_symgen_pkg.sv
// Shared types and constants for the QPSK symbol generator and the receive chain.
package qpsk_tx_symgen_pkg;

   localparam int unsigned SAMPLE_W    = 15;
   localparam int unsigned AMP_DEFAULT = 8191;

   typedef logic signed [SAMPLE_W-1:0] sample_t;

   // Nominal constellation levels shared with the gardner_sync receiver chain.
   localparam sample_t AMP_POS = sample_t'(AMP_DEFAULT);
   localparam sample_t AMP_NEG = -AMP_POS;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_DATA,
      ST_TAIL
   } state_t;

   // NRZ mapping: bit 0 -> +amp, bit 1 -> -amp.
   function automatic sample_t map_bit(input logic b, input sample_t amp);
      return b ? -amp : amp;
   endfunction

endpackage

// File: rtl/qpsk_bit_mapper.sv
// Collects payload bits into I/Q pairs and maps a complete pair to constellation levels.
module qpsk_bit_mapper
   import qpsk_tx_symgen_pkg::*;
#(
   parameter int unsigned AMP = AMP_DEFAULT
)
(
   input  logic    clk,
   input  logic    rst_n,
   input  logic    clear,
   input  logic    active_nxt,
   input  logic    consume,
   input  logic    bit_in,
   input  logic    bit_valid,
   input  logic    bit_last,
   output logic    bit_ready,
   output logic    pair_valid_c,
   output logic    pair_last_c,
   output sample_t sym_i_c,
   output sample_t sym_q_c
);

   localparam sample_t AMP_S = sample_t'(AMP);

   logic [1:0] fill;
   logic [1:0] fill_nxt;
   logic [1:0] pair_buf;
   logic [1:0] buf_nxt;
   logic       last_seen;
   logic       last_nxt;
   logic       ready_nxt;
   logic       accept_c;

   // Fill/consume bookkeeping; a lone final bit is padded with a 0 in Q.
   always_comb begin
      fill_nxt = fill;
      buf_nxt  = pair_buf;
      last_nxt = last_seen;
      accept_c = bit_valid && bit_ready;
      if (clear) begin
         fill_nxt = 2'd0;
         last_nxt = 1'b0;
      end else begin
         if (consume) begin
            fill_nxt = 2'd0;
         end
         if (accept_c) begin
            if (fill_nxt == 2'd0) begin
               buf_nxt[0] = bit_in;
               if (bit_last) begin
                  buf_nxt[1] = 1'b0;
                  fill_nxt   = 2'd2;
               end else begin
                  fill_nxt   = 2'd1;
               end
            end else begin
               buf_nxt[1] = bit_in;
               fill_nxt   = 2'd2;
            end
            if (bit_last) begin
               last_nxt = 1'b1;
            end
         end
      end
      ready_nxt = active_nxt && (fill_nxt < 2'd2) && !last_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fill      <= 2'd0;
         pair_buf  <= 2'b00;
         last_seen <= 1'b0;
         bit_ready <= 1'b0;
      end else begin
         fill      <= fill_nxt;
         pair_buf  <= buf_nxt;
         last_seen <= last_nxt;
         bit_ready <= ready_nxt;
      end
   end

   // Once the final bit is in, no further bits enter, so a full buffer is the last pair.
   assign pair_valid_c = (fill == 2'd2);
   assign pair_last_c  = last_seen;
   assign sym_i_c      = map_bit(pair_buf[0], AMP_S);
   assign sym_q_c      = map_bit(pair_buf[1], AMP_S);

endmodule

// File: rtl/qpsk_tx_symgen.sv
// QPSK baseband symbol generator: alternating preamble, mapped payload pairs, one-symbol tail.
module qpsk_tx_symgen
   import qpsk_tx_symgen_pkg::*;
#(
   parameter int unsigned SPS     = 8,
   parameter int unsigned PRE_LEN = 32,
   parameter int unsigned AMP     = AMP_DEFAULT
)
(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic                       bit_in,
   input  logic                       bit_valid,
   input  logic                       bit_last,
   output logic                       bit_ready,
   output logic signed [SAMPLE_W-1:0] data_out_I,
   output logic signed [SAMPLE_W-1:0] data_out_Q,
   output logic                       sym_strobe,
   output logic                       busy,
   output logic                       underrun
);

   localparam int unsigned CNT_W = (SPS > 2) ? $clog2(SPS) : 1;
   localparam int unsigned PRE_W = $clog2(PRE_LEN + 1);
   localparam sample_t     AMP_S = sample_t'(AMP);

   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_nxt;
   logic [PRE_W-1:0]   pre_cnt;
   logic [PRE_W-1:0]   pre_nxt;
   sample_t            i_nxt;
   sample_t            q_nxt;
   logic               strobe_nxt;
   logic               under_nxt;
   logic               busy_nxt;
   logic               wrap_c;
   logic               load_data_c;
   logic               consume_c;
   logic               frame_start_c;
   logic               active_nxt_c;
   logic               pair_valid_c;
   logic               pair_last_c;
   sample_t            sym_i_c;
   sample_t            sym_q_c;

   qpsk_bit_mapper #(
      .AMP (AMP)
   ) u_mapper (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear        (frame_start_c),
      .active_nxt   (active_nxt_c),
      .consume      (consume_c),
      .bit_in       (bit_in),
      .bit_valid    (bit_valid),
      .bit_last     (bit_last),
      .bit_ready    (bit_ready),
      .pair_valid_c (pair_valid_c),
      .pair_last_c  (pair_last_c),
      .sym_i_c      (sym_i_c),
      .sym_q_c      (sym_q_c)
   );

   assign wrap_c = (cnt == CNT_W'(SPS - 1));

   // Next-state, counters and next output sample.
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      pre_nxt       = pre_cnt;
      i_nxt         = data_out_I;
      q_nxt         = data_out_Q;
      strobe_nxt    = 1'b0;
      under_nxt     = 1'b0;
      load_data_c   = 1'b0;
      consume_c     = 1'b0;
      frame_start_c = 1'b0;
      unique case (state)
         ST_IDLE: begin
            cnt_nxt = '0;
            i_nxt   = '0;
            q_nxt   = '0;
            if (start) begin
               state_nxt     = ST_PREAMBLE;
               pre_nxt       = PRE_W'(1);
               i_nxt         = AMP_S;
               q_nxt         = AMP_S;
               strobe_nxt    = 1'b1;
               frame_start_c = 1'b1;
            end
         end
         ST_PREAMBLE: begin
            if (wrap_c) begin
               cnt_nxt    = '0;
               strobe_nxt = 1'b1;
               if (pre_cnt == PRE_W'(PRE_LEN)) begin
                  state_nxt   = ST_DATA;
                  load_data_c = 1'b1;
               end else begin
                  pre_nxt = pre_cnt + PRE_W'(1);
                  i_nxt   = pre_cnt[0] ? -AMP_S : AMP_S;
                  q_nxt   = i_nxt;
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         ST_DATA: begin
            if (wrap_c) begin
               cnt_nxt     = '0;
               strobe_nxt  = 1'b1;
               load_data_c = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         ST_TAIL: begin
            if (wrap_c) begin
               state_nxt = ST_IDLE;
               cnt_nxt   = '0;
               i_nxt     = '0;
               q_nxt     = '0;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
      // Data symbol boundary: take a complete pair, otherwise emit silence and flag it.
      if (load_data_c) begin
         if (pair_valid_c) begin
            i_nxt     = sym_i_c;
            q_nxt     = sym_q_c;
            consume_c = 1'b1;
            if (pair_last_c) begin
               state_nxt = ST_TAIL;
            end
         end else begin
            i_nxt     = '0;
            q_nxt     = '0;
            under_nxt = 1'b1;
         end
      end
      busy_nxt     = (state_nxt != ST_IDLE);
      active_nxt_c = (state_nxt == ST_PREAMBLE) || (state_nxt == ST_DATA);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         pre_cnt    <= '0;
         data_out_I <= '0;
         data_out_Q <= '0;
         sym_strobe <= 1'b0;
         busy       <= 1'b0;
         underrun   <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         pre_cnt    <= pre_nxt;
         data_out_I <= i_nxt;
         data_out_Q <= q_nxt;
         sym_strobe <= strobe_nxt;
         busy       <= busy_nxt;
         underrun   <= under_nxt;
      end
   end

endmodule

// File: doc/qpsk_tx_symgen.md
QPSK_TX_SYMGEN -- requirements
Module: qpsk_tx_symgen

Interface
REQ-001 Parameter SPS, default 8: samples per symbol, 2..64.
REQ-002 Parameter PRE_LEN, default 32: preamble length in symbols, 1..255.
REQ-003 Parameter AMP, default 8191: output magnitude, positive, fits 15-bit signed.
REQ-004 clk  input  1: single clock, 500 kHz sample rate.
REQ-005 rst_n  input  1: reset, asynchronous, active-low.
REQ-006 start  input  1: single-cycle pulse that starts a frame.
REQ-007 bit_in  input  1: payload bit.
REQ-008 bit_valid  input  1: bit_in is valid.
REQ-009 bit_last  input  1: qualifies bit_in as the final payload bit of the frame.
REQ-010 bit_ready  output  1: module accepts bit_in this cycle.
REQ-011 data_out_I  output  15: signed I-channel baseband sample, one per clk.
REQ-012 data_out_Q  output  15: signed Q-channel baseband sample, one per clk.
REQ-013 sym_strobe  output  1: high on the first sample of each symbol.
REQ-014 busy  output  1: high while not in IDLE.
REQ-015 underrun  output  1: single-cycle pulse when a DATA symbol boundary finds no complete bit pair.

Function
REQ-016 FSM states: IDLE, PREAMBLE, DATA, TAIL.
- IDLE -> PREAMBLE on start.
- PREAMBLE -> DATA after PRE_LEN symbols.
- DATA -> TAIL when the last pair loads.
- TAIL -> IDLE after that symbol's SPS samples.
REQ-017 start SHALL be ignored in any state other than IDLE.
REQ-018 Sample counter SHALL run 0..SPS-1 in non-IDLE states, wrap to 0, and hold at 0 in IDLE.
REQ-019 A symbol SHALL load when the counter wraps, and on the first non-IDLE cycle.
REQ-020 sym_strobe SHALL be high exactly when the output carries sample 0 of a symbol.
REQ-021 Outputs SHALL be registered: with start high in cycle t, the first preamble sample and sym_strobe SHALL appear in cycle t+1.
REQ-022 Each symbol SHALL be held constant for SPS consecutive cycles (rectangular NRZ).
REQ-023 Preamble symbols SHALL alternate, starting with (+AMP,+AMP), then (-AMP,-AMP), and so on.
REQ-024 Mapping: first bit of a pair -> I, second -> Q; bit 0 -> +AMP, bit 1 -> -AMP.
REQ-025 A 2-bit pair buffer with fill count 0..2 SHALL collect bits.
- A bit transfers when bit_valid and bit_ready are both high.
- bit_ready = (state is PREAMBLE or DATA) and fill < 2, and no bit_last has yet been accepted in the current frame.
REQ-026 Buffer filling SHALL start during PREAMBLE, so the first DATA symbol is available without underrun.
REQ-027 At a DATA boundary with fill==2, the pair SHALL load and fill SHALL clear.
- A transfer in the same cycle SHALL be accepted and count as fill 1 after the clear.
REQ-028 At a DATA boundary with fill<2 and no bit_last accepted, the symbol SHALL be (0,0), underrun SHALL pulse, and buffered bits SHALL be kept.
REQ-029 If bit_last is accepted as the first bit of a pair, Q SHALL be padded with bit 0.
- The pair counts as complete.
REQ-030 The symbol carrying the last bit SHALL move the FSM to TAIL.
REQ-031 In IDLE, outputs SHALL be 0 with sym_strobe low.
- After TAIL, outputs SHALL return to 0 on the cycle after the final sample.

Reset
REQ-032 On rst_n low, asynchronously:
- state = IDLE; counter, fill and preamble count = 0.
- data_out_I/Q = 0; sym_strobe, busy, underrun, bit_ready = 0.
REQ-033 Reset mid-frame SHALL abort the frame with no further samples.
- Buffered bits SHALL be discarded.
- Operation SHALL resume only on a new start after rst_n deasserts.

Structure
REQ-034 A shared package SHALL hold:
- sample width (15);
- the state enumeration;
- the +AMP/-AMP constants used by both the modulator and the gardner_sync receiver chain.
REQ-035 Bit pairing and mapping SHALL be one sub-module, qpsk_bit_mapper.
- Buffer, fill count, ready logic, mapping.
- The top level keeps the FSM, counters and output registers.

Verification
REQ-036 Reset mid-DATA (SPS=8, PRE_LEN=4) -> all outputs 0 in the same cycle; no output activity until the next start.
REQ-037 Preamble (SPS=8, PRE_LEN=4, start at t) -> in t+1..t+32: (+8191,+8191) x8, (-8191,-8191) x8, then that pair again; sym_strobe at t+1, t+9, t+17, t+25.
REQ-038 Frame with bits 0,1,1,0 (last on 4th), source always valid -> DATA symbols (+8191,-8191) then (-8191,+8191), 8 samples each; busy falls and outputs return to 0 after the 16th DATA sample.
REQ-039 Source stalls during the second pair -> that symbol is (0,0) for 8 samples with one underrun pulse at its sym_strobe; the delayed pair appears in the following symbol.
REQ-040 Odd frame with bits 1,0,1, last on 3rd -> symbols (-8191,+8191) then (-8191,+8191) (Q padded with 0); bit_ready stays low after the last bit is accepted.
REQ-041 start pulsed during PREAMBLE and DATA -> no effect on the sequence; SPS=2 corner: symbol held exactly 2 cycles, sym_strobe every 2nd cycle.
